sensor_event_ctrl: RTL and testbench

Downstream consumer of the three ADC voltage words (light, sound, temperature, in millivolts). The block samples them on a programmable tick and block-averages each channel over 2^AVG_LOG2 samples. It then applies hysteresis thresholds to drive three status flags (`dark`, `noisy`, `hot`). Flag changes are reported to the home controller through a valid/ready event port that never drops a change.

---
 rtl/smart_home_pkg.sv | 40 ++++
 rtl/sensor_event_ctrl_if.sv | 32 +++
 rtl/chan_avg.sv | 59 +++++
 rtl/sensor_event_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sensor_event_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/smart_home_pkg.sv
// ----------------------------------------------------------------------------
// smart_home_pkg
// Shared types and constants for the smart-home sensor blocks.
//   mv_t       : 13-bit unsigned millivolt word produced by the ADC front end.
//   flags_t    : status flag vector, indexed by FLAG_DARK / FLAG_NOISY / FLAG_HOT.
//   *_MV_DEF   : default hysteresis thresholds in millivolts.
//   hyst_next  : one hysteresis step (set has priority over clear).
// ----------------------------------------------------------------------------
package smart_home_pkg;

    localparam int MV_W      = 13;
    localparam int NUM_FLAGS = 3;

    typedef logic [MV_W-1:0]      mv_t;
    typedef logic [NUM_FLAGS-1:0] flags_t;

    localparam int FLAG_DARK  = 0;
    localparam int FLAG_NOISY = 1;
    localparam int FLAG_HOT   = 2;

    localparam mv_t LIGHT_DARK_MV_DEF   = 13'd800;
    localparam mv_t LIGHT_BRIGHT_MV_DEF = 13'd1200;
    localparam mv_t SOUND_HI_MV_DEF     = 13'd3000;
    localparam mv_t SOUND_LO_MV_DEF     = 13'd2500;
    localparam mv_t TEMP_HI_MV_DEF      = 13'd1500;
    localparam mv_t TEMP_LO_MV_DEF      = 13'd1400;
    localparam int  SOUND_HOLD_DEF      = 3;

    // Between the two thresholds the flag keeps its previous value.
    function automatic logic hyst_next(input logic cur, input logic set_c, input logic clr_c);
        if (set_c) begin
            return 1'b1;
        end
        if (clr_c) begin
            return 1'b0;
        end
        return cur;
    endfunction

endpackage

// File: rtl/sensor_event_ctrl_if.sv
// ----------------------------------------------------------------------------
// sensor_event_ctrl_if
// Valid/ready event port towards the home controller.
//   event_valid : an event is pending.
//   event_mask  : flag bits that toggled since the last accepted event.
//   event_flags : flag snapshot taken at the most recent merge.
//   event_ready : consumer accepts the pending event when high with event_valid.
// Modports: master = event producer (sensor_event_ctrl), slave = consumer.
// ----------------------------------------------------------------------------
interface sensor_event_ctrl_if;
    import smart_home_pkg::*;

    logic   event_valid;
    flags_t event_mask;
    flags_t event_flags;
    logic   event_ready;

    modport master (
        output event_valid,
        output event_mask,
        output event_flags,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_mask,
        input  event_flags,
        output event_ready
    );

endinterface

// File: rtl/chan_avg.sv
// ----------------------------------------------------------------------------
// chan_avg
// Block averager for one sensor channel: accumulates one sample per tick and
// publishes the truncated mean of every 2^AVG_LOG2 samples.
//   clk, reset_n : clock, asynchronous active-low reset.
//   tick         : sample strobe.
//   sample       : channel input in mV.
//   avg          : latest block average, updated one cycle after the last tick.
//   done         : one-cycle pulse coincident with a fresh avg.
// ----------------------------------------------------------------------------
module chan_avg
    import smart_home_pkg::*;
#(
    parameter int AVG_LOG2 = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  mv_t  sample,
    output mv_t  avg,
    output logic done
);

    // Wide enough for 2^AVG_LOG2 full-scale samples, so the sum never wraps.
    localparam int ACC_W = MV_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [AVG_LOG2-1:0] cnt;

    assign acc_sum = acc + ACC_W'(sample);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc  <= '0;
            cnt  <= '0;
            avg  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (tick) begin
                if (cnt == '1) begin
                    // Last sample of the block goes straight into the result,
                    // and the accumulator restarts empty for the next block.
                    avg  <= acc_sum[ACC_W-1:AVG_LOG2];
                    acc  <= '0;
                    cnt  <= '0;
                    done <= 1'b1;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + AVG_LOG2'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sensor_event_ctrl.sv
// ----------------------------------------------------------------------------
// sensor_event_ctrl
// Samples the light/sound/temperature voltage words on a programmable tick,
// block-averages each channel, derives the dark/noisy/hot status flags with
// hysteresis and reports every flag change on a valid/ready event port.
//   clk, reset_n                 : clock, asynchronous active-low reset.
//   volLight, volSound, volTemp  : upstream voltage words (mV).
//   avg_light, avg_sound, avg_temp : latest block averages.
//   avg_valid                    : one-cycle pulse when the averages update.
//   flags                        : [FLAG_DARK], [FLAG_NOISY], [FLAG_HOT].
//   evt                          : event port (master side).
// All outputs come straight from flops; event_ready only acts at the clock.
// ----------------------------------------------------------------------------
module sensor_event_ctrl
    import smart_home_pkg::*;
#(
    parameter int  TICK_DIV        = 50000,
    parameter int  AVG_LOG2        = 4,
    parameter mv_t LIGHT_DARK_MV   = LIGHT_DARK_MV_DEF,
    parameter mv_t LIGHT_BRIGHT_MV = LIGHT_BRIGHT_MV_DEF,
    parameter mv_t SOUND_HI_MV     = SOUND_HI_MV_DEF,
    parameter mv_t SOUND_LO_MV     = SOUND_LO_MV_DEF,
    parameter int  SOUND_HOLD      = SOUND_HOLD_DEF,
    parameter mv_t TEMP_HI_MV      = TEMP_HI_MV_DEF,
    parameter mv_t TEMP_LO_MV      = TEMP_LO_MV_DEF
) (
    input  logic   clk,
    input  logic   reset_n,
    input  mv_t    volLight,
    input  mv_t    volSound,
    input  mv_t    volTemp,
    output mv_t    avg_light,
    output mv_t    avg_sound,
    output mv_t    avg_temp,
    output logic   avg_valid,
    output flags_t flags,
    sensor_event_ctrl_if.master evt
);

    localparam int             TICK_W    = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [3:0]     HOLD_MAX  = 4'(SOUND_HOLD);

    // ------------------------------------------------------------------
    // Sample tick
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel averaging
    // ------------------------------------------------------------------
    logic [2:0] chan_done;

    chan_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_light (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .sample  (volLight),
        .avg     (avg_light),
        .done    (chan_done[0])
    );

    chan_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_sound (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .sample  (volSound),
        .avg     (avg_sound),
        .done    (chan_done[1])
    );

    chan_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_temp (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .sample  (volTemp),
        .avg     (avg_temp),
        .done    (chan_done[2])
    );

    // The three channels share tick and reset, so their done pulses coincide.
    assign avg_valid = &chan_done;

    // ------------------------------------------------------------------
    // Hysteresis: candidate next flags from the current averages.
    // Only committed in the avg_valid cycle, so they land one cycle later.
    // ------------------------------------------------------------------
    logic [3:0] hold_cnt;
    logic [3:0] hold_nxt;
    flags_t     flags_nxt;

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path leaves it unassigned and no latch can be inferred.
        flags_nxt = flags;
        hold_nxt  = '0;

        flags_nxt[FLAG_DARK] = hyst_next(flags[FLAG_DARK],
                                         avg_light < LIGHT_DARK_MV,
                                         avg_light > LIGHT_BRIGHT_MV);

        flags_nxt[FLAG_HOT]  = hyst_next(flags[FLAG_HOT],
                                         avg_temp > TEMP_HI_MV,
                                         avg_temp < TEMP_LO_MV);

        // Loud averages must run consecutively; any quieter one restarts the count.
        if (avg_sound > SOUND_HI_MV) begin
            hold_nxt = (hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + 4'd1;
        end

        flags_nxt[FLAG_NOISY] = hyst_next(flags[FLAG_NOISY],
                                          hold_nxt == HOLD_MAX,
                                          avg_sound < SOUND_LO_MV);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags    <= '0;
            hold_cnt <= '0;
        end else if (avg_valid) begin
            flags    <= flags_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Event register
    // ------------------------------------------------------------------
    logic   ev_valid_q;
    flags_t ev_mask_q;
    flags_t ev_flags_q;
    logic   accept;
    flags_t change;

    assign accept = ev_valid_q & evt.event_ready;
    assign change = avg_valid ? (flags_nxt ^ flags) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ev_valid_q <= 1'b0;
            ev_mask_q  <= '0;
            ev_flags_q <= '0;
        end else begin
            // Clearing on accept before merging keeps a same-cycle change alive.
            ev_mask_q <= (accept ? '0 : ev_mask_q) | change;
            if (change != '0) begin
                ev_valid_q <= 1'b1;
                ev_flags_q <= flags_nxt;
            end else if (accept) begin
                ev_valid_q <= 1'b0;
            end
        end
    end

    assign evt.event_valid = ev_valid_q;
    assign evt.event_mask  = ev_mask_q;
    assign evt.event_flags = ev_flags_q;

endmodule

// File: tb/tb_sensor_event_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sensor_event_ctrl
// Self-checking bench for sensor_event_ctrl with TICK_DIV=4, AVG_LOG2=2.
// A behavioural model (sample sums, divided means, rule-based flags, pending
// event record) is stepped once per clock and compared on every falling edge.
// A table of block vectors carries hand-derived expectations for the
// documented scenarios; a randomized phase follows.
// ----------------------------------------------------------------------------
module tb_sensor_event_ctrl;
    import smart_home_pkg::*;

    localparam int TD   = 4;
    localparam int AL   = 2;
    localparam int NS   = 1 << AL;
    localparam int HALF = 5;

    localparam int DARK_MV   = 800;
    localparam int BRIGHT_MV = 1200;
    localparam int S_HI_MV   = 3000;
    localparam int S_LO_MV   = 2500;
    localparam int HOLD      = 3;
    localparam int T_HI_MV   = 1500;
    localparam int T_LO_MV   = 1400;

    typedef enum int {RDY_LOW, RDY_HIGH, RDY_PULSE} rdy_e;

    typedef struct {
        logic [NS-1:0][12:0] light;
        mv_t                 sound;
        mv_t                 temp;
        rdy_e                rdy;
        bit                  pre_reset;
        int                  exp_l;
        int                  exp_s;
        int                  exp_t;
        logic [2:0]          exp_flags;
        logic                exp_ev_valid;
        logic [2:0]          exp_mask;
        logic [2:0]          exp_ev_flags;
    } vec_t;

    logic   clk = 1'b0;
    logic   reset_n;
    mv_t    vol_light, vol_sound, vol_temp;
    mv_t    avg_light, avg_sound, avg_temp;
    logic   avg_valid;
    flags_t flags;
    logic   event_ready;

    sensor_event_ctrl_if evt_if();
    assign evt_if.event_ready = event_ready;

    sensor_event_ctrl #(
        .TICK_DIV (TD),
        .AVG_LOG2 (AL)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .volLight  (vol_light),
        .volSound  (vol_sound),
        .volTemp   (vol_temp),
        .avg_light (avg_light),
        .avg_sound (avg_sound),
        .avg_temp  (avg_temp),
        .avg_valid (avg_valid),
        .flags     (flags),
        .evt       (evt_if)
    );

    always #HALF clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int       ph;
    int       nsamp;
    int       sum_l, sum_s, sum_t;
    int       m_avg_l, m_avg_s, m_avg_t;
    bit       m_avg_valid;
    bit [2:0] m_flags;
    int       m_hold;
    bit       m_ev_valid;
    bit [2:0] m_ev_mask, m_ev_flags;

    function automatic void model_reset();
        ph = 0; nsamp = 0;
        sum_l = 0; sum_s = 0; sum_t = 0;
        m_avg_l = 0; m_avg_s = 0; m_avg_t = 0; m_avg_valid = 1'b0;
        m_flags = '0; m_hold = 0;
        m_ev_valid = 1'b0; m_ev_mask = '0; m_ev_flags = '0;
    endfunction

    function automatic bit [2:0] model_next_flags();
        bit [2:0] nf;
        nf = m_flags;
        if (m_avg_l < DARK_MV)        nf[0] = 1'b1;
        else if (m_avg_l > BRIGHT_MV) nf[0] = 1'b0;
        if (m_avg_t > T_HI_MV)        nf[2] = 1'b1;
        else if (m_avg_t < T_LO_MV)   nf[2] = 1'b0;
        m_hold = (m_avg_s > S_HI_MV) ? ((m_hold < HOLD) ? m_hold + 1 : HOLD) : 0;
        if (m_hold == HOLD)           nf[1] = 1'b1;
        else if (m_avg_s < S_LO_MV)   nf[1] = 1'b0;
        return nf;
    endfunction

    task automatic check_all();
        check("avg_light",   avg_light,          m_avg_l);
        check("avg_sound",   avg_sound,          m_avg_s);
        check("avg_temp",    avg_temp,           m_avg_t);
        check("avg_valid",   avg_valid,          m_avg_valid);
        check("flags",       flags,              m_flags);
        check("event_valid", evt_if.event_valid, m_ev_valid);
        check("event_mask",  evt_if.event_mask,  m_ev_mask);
        check("event_flags", evt_if.event_flags, m_ev_flags);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_avg_light"},   avg_light,          0);
        check({tag, "_avg_sound"},   avg_sound,          0);
        check({tag, "_avg_temp"},    avg_temp,           0);
        check({tag, "_avg_valid"},   avg_valid,          0);
        check({tag, "_flags"},       flags,              0);
        check({tag, "_event_valid"}, evt_if.event_valid, 0);
        check({tag, "_event_mask"},  evt_if.event_mask,  0);
        check({tag, "_event_flags"}, evt_if.event_flags, 0);
    endtask

    // One clock: advance the model across the rising edge, then compare on
    // the falling edge.
    task automatic step();
        bit       tick_now, upd_now, acc;
        bit [2:0] nf, chg;
        tick_now = (ph == TD - 1);
        upd_now  = m_avg_valid;
        acc      = m_ev_valid && (event_ready === 1'b1);
        @(posedge clk);
        ph = (ph + 1) % TD;
        m_avg_valid = 1'b0;
        if (acc) begin
            m_ev_mask  = '0;
            m_ev_valid = 1'b0;
        end
        if (upd_now) begin
            nf  = model_next_flags();
            chg = nf ^ m_flags;
            if (chg != 0) begin
                m_ev_mask  = m_ev_mask | chg;
                m_ev_flags = nf;
                m_ev_valid = 1'b1;
            end
            m_flags = nf;
        end
        if (tick_now) begin
            sum_l += int'(vol_light);
            sum_s += int'(vol_sound);
            sum_t += int'(vol_temp);
            nsamp++;
            if (nsamp == NS) begin
                m_avg_l = sum_l / NS;
                m_avg_s = sum_s / NS;
                m_avg_t = sum_t / NS;
                m_avg_valid = 1'b1;
                sum_l = 0; sum_s = 0; sum_t = 0;
                nsamp = 0;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    // Drive one sample and run until the tick that captures it has passed.
    task automatic sample(input int l, input int s, input int t);
        vol_light = mv_t'(l);
        vol_sound = mv_t'(s);
        vol_temp  = mv_t'(t);
        do step(); while (ph != 0);
    endtask

    // Three samples of a new block, then reset in the middle of a low phase.
    task automatic mid_block_reset();
        for (int k = 0; k < NS - 1; k++) sample(100, 4000, 4000);
        check("pre_rst_noisy",       flags[FLAG_NOISY],  1);
        check("pre_rst_event_valid", evt_if.event_valid, 1);
        #2 reset_n = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        @(negedge clk);
        check_zero("rst_hold");
        reset_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    vec_t vecs[$];

    function automatic logic [NS-1:0][12:0] rep(input int v);
        return {NS{mv_t'(v)}};
    endfunction

    function automatic void add(input logic [NS-1:0][12:0] l, input int s, input int t,
                                input rdy_e r, input bit pr,
                                input int el, input int es, input int et,
                                input logic [2:0] ef, input logic ev,
                                input logic [2:0] em, input logic [2:0] eef);
        vec_t v;
        v.light = l;   v.sound = mv_t'(s); v.temp = mv_t'(t);
        v.rdy = r;     v.pre_reset = pr;
        v.exp_l = el;  v.exp_s = es;       v.exp_t = et;
        v.exp_flags = ef; v.exp_ev_valid = ev; v.exp_mask = em; v.exp_ev_flags = eef;
        vecs.push_back(v);
    endfunction

    int lat;
    bit got;
    int bl, bs, bt;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // averaging (truncating) and band hold
        add({13'd1004, 13'd1002, 13'd1001, 13'd1000}, 2000, 1450, RDY_HIGH, 0, 1001, 2000, 1450, 3'b000, 0, 3'b000, 3'b000);
        // light hysteresis
        add(rep(700),  2000, 1450, RDY_HIGH, 0,  700, 2000, 1450, 3'b001, 1, 3'b001, 3'b001);
        add(rep(1000), 2000, 1450, RDY_HIGH, 0, 1000, 2000, 1450, 3'b001, 0, 3'b000, 3'b001);
        add(rep(1300), 2000, 1450, RDY_HIGH, 0, 1300, 2000, 1450, 3'b000, 1, 3'b001, 3'b000);
        // sound hold: 3100 3100 2800 3100 3100 3100, then 2600, 2400
        add(rep(1000), 3100, 1450, RDY_HIGH, 0, 1000, 3100, 1450, 3'b000, 0, 3'b000, 3'b000);
        add(rep(1000), 3100, 1450, RDY_HIGH, 0, 1000, 3100, 1450, 3'b000, 0, 3'b000, 3'b000);
        add(rep(1000), 2800, 1450, RDY_HIGH, 0, 1000, 2800, 1450, 3'b000, 0, 3'b000, 3'b000);
        add(rep(1000), 3100, 1450, RDY_HIGH, 0, 1000, 3100, 1450, 3'b000, 0, 3'b000, 3'b000);
        add(rep(1000), 3100, 1450, RDY_HIGH, 0, 1000, 3100, 1450, 3'b000, 0, 3'b000, 3'b000);
        add(rep(1000), 3100, 1450, RDY_HIGH, 0, 1000, 3100, 1450, 3'b010, 1, 3'b010, 3'b010);
        add(rep(1000), 2600, 1450, RDY_HIGH, 0, 1000, 2600, 1450, 3'b010, 0, 3'b000, 3'b010);
        add(rep(1000), 2400, 1450, RDY_HIGH, 0, 1000, 2400, 1450, 3'b000, 1, 3'b010, 3'b000);
        add(rep(1000), 2000, 1450, RDY_HIGH, 0, 1000, 2000, 1450, 3'b000, 0, 3'b000, 3'b000);
        // backpressure: hot, then dark merge; accept coincides with hot clearing
        add(rep(1000), 2000, 1600, RDY_LOW,   0, 1000, 2000, 1600, 3'b100, 1, 3'b100, 3'b100);
        add(rep(700),  2000, 1600, RDY_LOW,   0,  700, 2000, 1600, 3'b101, 1, 3'b101, 3'b101);
        add(rep(700),  2000, 1300, RDY_PULSE, 0,  700, 2000, 1300, 3'b001, 1, 3'b100, 3'b001);
        // build up noisy with the event still pending
        add(rep(1000), 3100, 1450, RDY_LOW, 0, 1000, 3100, 1450, 3'b001, 1, 3'b100, 3'b001);
        add(rep(1000), 3100, 1450, RDY_LOW, 0, 1000, 3100, 1450, 3'b001, 1, 3'b100, 3'b001);
        add(rep(1000), 3100, 1450, RDY_LOW, 0, 1000, 3100, 1450, 3'b011, 1, 3'b110, 3'b011);
        // reset after 3 of 4 samples; next average uses post-reset samples only
        add({13'd1004, 13'd1002, 13'd1001, 13'd1000}, 2000, 1450, RDY_HIGH, 1, 1001, 2000, 1450, 3'b000, 0, 3'b000, 3'b000);

        // ---------------- reset with random inputs ----------------
        reset_n = 1'b0;
        event_ready = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vol_light   = mv_t'($urandom_range(0, 8191));
            vol_sound   = mv_t'($urandom_range(0, 8191));
            vol_temp    = mv_t'($urandom_range(0, 8191));
            event_ready = 1'($urandom_range(0, 1));
            #1 check_zero("reset");
        end
        @(negedge clk);
        vol_light = 13'd1000; vol_sound = 13'd2000; vol_temp = 13'd1450;
        event_ready = 1'b1;
        reset_n = 1'b1;

        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            step();
            lat++;
            if (avg_valid === 1'b1) got = 1'b1;
        end
        check("first_avg_latency", lat, NS * TD);

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].pre_reset) mid_block_reset();
            event_ready = (vecs[i].rdy == RDY_HIGH);
            for (int k = 0; k < NS; k++) sample(int'(vecs[i].light[k]), int'(vecs[i].sound), int'(vecs[i].temp));
            check($sformatf("vec%0d_avg_valid", i), avg_valid, 1);
            check($sformatf("vec%0d_avg_light", i), avg_light, vecs[i].exp_l);
            check($sformatf("vec%0d_avg_sound", i), avg_sound, vecs[i].exp_s);
            check($sformatf("vec%0d_avg_temp",  i), avg_temp,  vecs[i].exp_t);
            if (vecs[i].rdy == RDY_PULSE) event_ready = 1'b1;
            step();
            if (vecs[i].rdy == RDY_PULSE) event_ready = 1'b0;
            check($sformatf("vec%0d_flags",       i), flags,              vecs[i].exp_flags);
            check($sformatf("vec%0d_event_valid", i), evt_if.event_valid, vecs[i].exp_ev_valid);
            check($sformatf("vec%0d_event_mask",  i), evt_if.event_mask,  vecs[i].exp_mask);
            check($sformatf("vec%0d_event_flags", i), evt_if.event_flags, vecs[i].exp_ev_flags);
        end

        // ---------------- randomized blocks, random ready every cycle ----------------
        for (int b = 0; b < 40; b++) begin
            bl = int'($urandom_range(600, 1400));
            bs = int'($urandom_range(2300, 3300));
            bt = int'($urandom_range(1300, 1600));
            for (int k = 0; k < NS; k++) begin
                vol_light = mv_t'(bl - 100 + int'($urandom_range(0, 200)));
                vol_sound = mv_t'(bs - 100 + int'($urandom_range(0, 200)));
                vol_temp  = mv_t'(bt - 100 + int'($urandom_range(0, 200)));
                do begin
                    event_ready = 1'($urandom_range(0, 1));
                    step();
                end while (ph != 0);
            end
        end
        event_ready = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
